mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the zerocore RAM interface. Serves the core's
//   unified read port (inst fetch) and masked write port from an internal
//   doubleword array. Read data returns after a fixed pipelined latency.
//   Sits outside zerocore in the sim top and replaces the external virtual RAM.
// PARAMETERS
//   ADDR_W      64            byte address width (matches ADDR_BUS)
//   DATA_W      64            data width (matches DATA_BUS); fixed 64
//   DEPTH       4096          number of 64-bit words in the array
//   BASE_ADDR   64'h8000_0000 byte address of word 0
//   RD_LAT      1             read latency in cycles, legal 1..4
// PORTS
//   clk          in   1       clock, all logic on rising edge
//   rst          in   1       synchronous reset, active-low (rst==0 resets)
//   ReadEnable   in   1       read request, sampled every cycle
//   ReadAddr     in   ADDR_W  byte read address
//   ReadData     out  DATA_W  read response data
//   ReadValid    out  1       ReadData holds a response this cycle
//   ReadErr      out  1       response was out-of-range (data forced 0)
//   WriteEnable  in   1       write request, sampled every cycle
//   WriteAddr    in   ADDR_W  byte write address, bits [2:0] ignored
//   WriteMask    in   DATA_W  bit-level write mask, 1 = bit written
//   WriteData    in   DATA_W  write data
//   WriteErr     out  1       one-cycle pulse: previous-cycle write dropped
//   rd_count     out  32      accepted reads, saturates at 32'hFFFF_FFFF
//   wr_count     out  32      committed writes, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//   - Reset (rst==0 at edge): ReadData=0, ReadValid=0, ReadErr=0,
//     WriteErr=0, rd_count=0, wr_count=0, read pipeline flushed. Array
//     contents are NOT reset. Reads in flight at reset are discarded and
//     never produce ReadValid.
//   - Index: idx = (addr - BASE_ADDR) >> 3. In range iff
//     addr >= BASE_ADDR and idx < DEPTH. Unsigned 64-bit compare; no wrap.
//   - Read: request sampled at edge N when ReadEnable=1. Response appears
//     with ReadValid=1 in the cycle after edge N+RD_LAT-1 (RD_LAT=1: valid
//     the cycle right after the sample edge). Fully pipelined: one new
//     read per cycle, responses in request order, no stalls or backpressure.
//   - Read data = mem[idx] >> (8*ReadAddr[2:0]), upper bytes zero-filled,
//     so ReadData[31:0] is the 32-bit word at ReadAddr for any 4-byte
//     aligned ReadAddr.
//   - Out-of-range read: ReadData=0, ReadErr=1, ReadValid=1, same latency.
//   - With no valid response, ReadData=0 and ReadErr=0.
//   - Write: committed at edge N when WriteEnable=1 and in range:
//     mem[idx] <= (mem[idx] & ~WriteMask) | (WriteData & WriteMask).
//     WriteMask=0 still counts as a committed write. Out-of-range write:
//     array unchanged, wr_count unchanged, WriteErr=1 for the cycle after N.
//   - Same-edge read and write to same word: write-first. The read returns
//     the merged value. Data is captured at the sample edge. Later writes
//     do not change responses already in flight.
//   - rd_count counts every sampled read, including out-of-range reads.
//     Both counters hold at all-ones.
//   - ReadEnable and WriteEnable are independent. Both can be accepted on
//     every cycle.
// TESTING
//   1 Reset: drive rst=0 for 2 cycles with ReadEnable=1 -> all outputs 0,
//     no ReadValid; then rst=1 -> first ReadValid exactly RD_LAT cycles
//     after the first sampled read.
//   2 Masked write: write 64'h1122_3344_5566_7788 to 0x8000_0000 with mask
//     all-ones, then WriteData=64'hFFFF..., mask=64'h0000_0000_FFFF_0000
//     -> read 0x8000_0000 returns 64'h1122_3344_FFFF_7788.
//   3 Sub-word read: after test 2, read 0x8000_0004 -> ReadData =
//     64'h0000_0000_1122_3344.
//   4 Back-to-back: reads to 0x8000_0000, _0008, _0010 on consecutive
//     cycles with RD_LAT=3 -> three consecutive ReadValid cycles, in order,
//     first one 3 cycles after the first request; rd_count=3.
//   5 Collision: same edge write 64'hA5 (mask all-ones) and read of
//     0x8000_0008 -> response 64'hA5; a write of 64'h5A one cycle later
//     does not alter that in-flight response.
//   6 Range: read 0x7FFF_FFF8 and write 0x8000_0000+8*DEPTH -> ReadErr=1
//     with ReadData=0; WriteErr pulses 1 cycle; wr_count unchanged; array
//     unchanged.

Source files
------------

// File: rtl/mem_responder_if.sv
// Core-to-memory RAM port bundle: unified read port, masked write port, status counters.
// Latency: none (wiring only).
// Backpressure: none; the responder accepts a read and a write every cycle.
interface mem_responder_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ReadEnable;
    logic [ADDR_W-1:0] ReadAddr;
    logic [DATA_W-1:0] ReadData;
    logic              ReadValid;
    logic              ReadErr;
    logic              WriteEnable;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteMask;
    logic [DATA_W-1:0] WriteData;
    logic              WriteErr;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    // Core side: issues requests, observes responses.
    modport master (
        output ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteMask, WriteData,
        input  ReadData, ReadValid, ReadErr, WriteErr, rd_count, wr_count
    );

    // Memory side: serves requests.
    modport slave (
        input  ReadEnable, ReadAddr, WriteEnable, WriteAddr, WriteMask, WriteData,
        output ReadData, ReadValid, ReadErr, WriteErr, rd_count, wr_count
    );
endinterface

// File: rtl/mem_responder.sv
// Doubleword RAM responder: serves a byte-addressed read port and a bit-masked write port.
// Latency: read data valid RD_LAT cycles after the sample edge; writes commit at the sample edge.
// Backpressure: none; fully pipelined, one read and one write accepted every cycle.
module mem_responder #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int                RD_LAT    = 1
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    // Storage array; contents survive reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Address decode for both ports: offset from base, word index, range check.
    logic [ADDR_W-1:0] r_off;
    logic [ADDR_W-1:0] w_off;
    logic              r_inr;
    logic              w_inr;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx;

    assign r_off = bus.ReadAddr  - BASE_ADDR;
    assign w_off = bus.WriteAddr - BASE_ADDR;
    // Unsigned compare against the base rejects addresses below it without wrapping.
    assign r_inr = (bus.ReadAddr  >= BASE_ADDR) && ((r_off >> 3) < ADDR_W'(DEPTH));
    assign w_inr = (bus.WriteAddr >= BASE_ADDR) && ((w_off >> 3) < ADDR_W'(DEPTH));
    assign r_idx = r_off[IDX_W+2:3];
    assign w_idx = w_off[IDX_W+2:3];

    logic              w_commit;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_dat_d;

    assign w_commit  = bus.WriteEnable && w_inr;
    assign wr_merged = (mem_q[w_idx] & ~bus.WriteMask) | (bus.WriteData & bus.WriteMask);

    // Read source: same-edge write to the same word wins, so the read sees the merged value.
    always_comb begin
        rd_word  = mem_q[r_idx];
        rd_dat_d = '0;
        if (w_commit && (w_idx == r_idx)) begin
            rd_word = wr_merged;
        end
        if (bus.ReadEnable && r_inr) begin
            rd_dat_d = rd_word >> {bus.ReadAddr[2:0], 3'b000};
        end
    end

    // Commit in-range writes; no reset so the array keeps its contents.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            mem_q[w_idx] <= wr_merged;
        end
    end

    // Read pipeline: stage 0 captures at the sample edge, the last stage drives the outputs.
    // Data is captured up front, so later writes cannot disturb responses in flight.
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Advance the read pipeline; reset flushes every stage so in-flight reads vanish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= bus.ReadEnable;
            err_q[0] <= bus.ReadEnable && !r_inr;
            dat_q[0] <= rd_dat_d;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    logic        werr_q;
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Write-drop pulse and saturating read/write counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            werr_q   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            werr_q <= bus.WriteEnable && !w_inr;
            if (bus.ReadEnable && (rd_cnt_q != 32'hFFFF_FFFF)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (w_commit && (wr_cnt_q != 32'hFFFF_FFFF)) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign bus.ReadValid = vld_q[RD_LAT-1];
    assign bus.ReadErr   = err_q[RD_LAT-1];
    assign bus.ReadData  = dat_q[RD_LAT-1];
    assign bus.WriteErr  = werr_q;
    assign bus.rd_count  = rd_cnt_q;
    assign bus.wr_count  = wr_cnt_q;
endmodule
